// File: rtl/mini_alu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mini_alu_core : registered 32-bit ALU with persistent NZCV flags         |
// | Optional multiplier (opcode 9) enabled by defining MINI_ALU_MUL_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mini_alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       instruction,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [4:0] c_OP_NOP  = 5'd0;
  localparam logic [4:0] c_OP_ANDS = 5'd1;
  localparam logic [4:0] c_OP_ORRS = 5'd2;
  localparam logic [4:0] c_OP_MVNS = 5'd3;
  localparam logic [4:0] c_OP_EORS = 5'd4;
  localparam logic [4:0] c_OP_ADCS = 5'd5;
  localparam logic [4:0] c_OP_ADDS = 5'd6;
  localparam logic [4:0] c_OP_SBCS = 5'd7;
  localparam logic [4:0] c_OP_SUB  = 5'd8;
  localparam logic [4:0] c_OP_MULS = 5'd9;
  localparam logic [4:0] c_OP_LSRS = 5'd10;
  localparam logic [4:0] c_OP_LSLS = 5'd11;
  localparam logic [4:0] c_OP_ASR  = 5'd12;
  localparam logic [4:0] c_OP_ROR  = 5'd13;
  localparam logic [4:0] c_OP_UXTB = 5'd14;
  localparam logic [4:0] c_OP_UXTH = 5'd15;
  localparam logic [4:0] c_OP_SXTB = 5'd16;
  localparam logic [4:0] c_OP_SXTH = 5'd17;
  localparam logic [4:0] c_OP_CMP  = 5'd18;

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_out_valid;

  logic [4:0]        w_sh;
  logic [4:0]        w_rsh;
  logic [WIDTH-1:0]  w_addb;
  logic              w_cin;
  logic [WIDTH:0]    w_sum;
  logic              w_add_v;
  logic [WIDTH:0]    w_lsr_ext;
  logic [WIDTH:0]    w_lsl_ext;
  logic signed [WIDTH:0] w_asr_ext;
  logic [WIDTH-1:0]  w_ror;
  logic [WIDTH-1:0]  w_val;
  logic              w_res_we;
  logic              w_nz_we;
  logic              w_c;
  logic              w_v;
  logic [WIDTH-1:0]  w_result_nxt;
  logic [3:0]        w_flags_nxt;

  assign w_sh  = num2[4:0];
  assign w_rsh = 5'd0 - w_sh;

  // Shifting through one extra bit position leaves the last bit shifted out
  // in the extension bit, which is exactly the shifter carry.
  assign w_lsr_ext = {num1, 1'b0} >> w_sh;
  assign w_lsl_ext = {1'b0, num1} << w_sh;
  assign w_asr_ext = $signed({num1, 1'b0}) >>> w_sh;
  assign w_ror     = (num1 >> w_sh) | (num1 << w_rsh);

`ifdef MINI_ALU_MUL_EN
  logic [WIDTH-1:0] w_mul;
  // Low half of a two's-complement product is independent of operand signedness.
  assign w_mul = num1 * num2;
`endif

  always_comb begin
    w_addb = num2;
    w_cin  = 1'b0;
    case (instruction)
      c_OP_ADCS: w_cin = r_flags[2];
      c_OP_SBCS: begin
        w_addb = ~num2;
        w_cin  = r_flags[2];
      end
      c_OP_SUB, c_OP_CMP: begin
        w_addb = ~num2;
        w_cin  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum   = {1'b0, num1} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_cin};
  assign w_add_v = (num1[WIDTH-1] == w_addb[WIDTH-1]) && (w_sum[WIDTH-1] != num1[WIDTH-1]);

  always_comb begin
    w_val    = '0;
    w_res_we = 1'b0;
    w_nz_we  = 1'b0;
    w_c      = r_flags[2];
    w_v      = r_flags[3];
    case (instruction)
      c_OP_NOP: ;
      c_OP_ANDS, c_OP_ORRS, c_OP_MVNS, c_OP_EORS: begin
        case (instruction)
          c_OP_ANDS: w_val = num1 & num2;
          c_OP_ORRS: w_val = num1 | num2;
          c_OP_MVNS: w_val = ~num1;
          default:   w_val = num1 ^ num2;
        endcase
        w_res_we = 1'b1;
        w_nz_we  = 1'b1;
        w_c      = 1'b0;
      end
      c_OP_ADCS, c_OP_ADDS, c_OP_SBCS, c_OP_SUB, c_OP_CMP: begin
        w_val    = w_sum[WIDTH-1:0];
        w_res_we = (instruction != c_OP_CMP);
        w_nz_we  = 1'b1;
        w_c      = w_sum[WIDTH];
        w_v      = w_add_v;
      end
`ifdef MINI_ALU_MUL_EN
      c_OP_MULS: begin
        w_val    = w_mul;
        w_res_we = 1'b1;
        w_nz_we  = 1'b1;
      end
`endif
      c_OP_LSRS: begin
        w_val    = w_lsr_ext[WIDTH:1];
        w_res_we = 1'b1;
        w_nz_we  = 1'b1;
        if (w_sh != 5'd0) w_c = w_lsr_ext[0];
      end
      c_OP_LSLS: begin
        w_val    = w_lsl_ext[WIDTH-1:0];
        w_res_we = 1'b1;
        w_nz_we  = 1'b1;
        if (w_sh != 5'd0) w_c = w_lsl_ext[WIDTH];
      end
      c_OP_ASR: begin
        w_val    = w_asr_ext[WIDTH:1];
        w_res_we = 1'b1;
        w_nz_we  = 1'b1;
        if (w_sh != 5'd0) w_c = w_asr_ext[0];
      end
      c_OP_ROR: begin
        w_val    = w_ror;
        w_res_we = 1'b1;
        w_nz_we  = 1'b1;
        if (w_sh != 5'd0) w_c = w_ror[WIDTH-1];
      end
      c_OP_UXTB: begin
        w_val    = {{(WIDTH-8){1'b0}}, num1[7:0]};
        w_res_we = 1'b1;
      end
      c_OP_UXTH: begin
        w_val    = {{(WIDTH-16){1'b0}}, num1[15:0]};
        w_res_we = 1'b1;
      end
      c_OP_SXTB: begin
        w_val    = {{(WIDTH-8){num1[7]}}, num1[7:0]};
        w_res_we = 1'b1;
      end
      c_OP_SXTH: begin
        w_val    = {{(WIDTH-16){num1[15]}}, num1[15:0]};
        w_res_we = 1'b1;
      end
      default: begin
        // Undefined opcodes (and MULS when the multiplier is absent) clear the result.
        w_val    = '0;
        w_res_we = 1'b1;
      end
    endcase
  end

  assign w_result_nxt = w_res_we ? w_val : r_result;
  assign w_flags_nxt  = {w_v, w_c,
                         w_nz_we ? (w_val == '0)     : r_flags[1],
                         w_nz_we ? w_val[WIDTH-1]    : r_flags[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_flags     <= 4'b0000;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result_nxt;
        r_flags  <= w_flags_nxt;
      end
    end
  end

  assign result    = r_result;
  assign flags     = r_flags;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mini_alu_core : directed vector table plus randomized model check     |
// | Expectations for opcode 9 follow MINI_ALU_MUL_EN.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mini_alu_core;

  localparam logic [4:0] NOP = 5'd0, ANDS = 5'd1, ORRS = 5'd2, MVNS = 5'd3, EORS = 5'd4;
  localparam logic [4:0] ADCS = 5'd5, ADDS = 5'd6, SBCS = 5'd7, SUB = 5'd8, MULS = 5'd9;
  localparam logic [4:0] LSRS = 5'd10, LSLS = 5'd11, ASR = 5'd12, ROR = 5'd13;
  localparam logic [4:0] UXTB = 5'd14, UXTH = 5'd15, SXTB = 5'd16, SXTH = 5'd17, CMP = 5'd18;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] er;
    logic [3:0]  ef;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  instruction;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t        vecs[$];
  logic [31:0] m_res;
  logic [3:0]  m_fl;
  logic        m_ov;

  always #5 clk = ~clk;

  mini_alu_core #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .num1(num1), .num2(num2), .out_valid(out_valid), .result(result), .flags(flags)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.er = er; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic vld, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst = r; in_valid = vld; instruction = op; num1 = a; num2 = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model: next architectural state from the opcode rules, using
  // wide integer arithmetic for carry/overflow and bit loops for shifts.
  task automatic model_step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, bb;
    logic        n, z, c, v, cin, upd_res, upd_nz;
    logic [32:0] s33;
    longint      ss;
    longint      lim;
    int          sh;
    r = '0; bb = b; cin = 1'b0; upd_res = 1'b0; upd_nz = 1'b0;
    c = m_fl[2]; v = m_fl[3];
    sh = int'(b[4:0]);
    lim = 64'sd2147483648;
    case (op)
      ANDS, ORRS, MVNS, EORS: begin
        r = (op == ANDS) ? (a & b) : (op == ORRS) ? (a | b) : (op == MVNS) ? ~a : (a ^ b);
        upd_res = 1'b1; upd_nz = 1'b1; c = 1'b0;
      end
      ADCS, ADDS, SBCS, SUB, CMP: begin
        if (op == SBCS || op == SUB || op == CMP) bb = ~b;
        cin = (op == ADCS || op == SBCS) ? m_fl[2] : (op == ADDS) ? 1'b0 : 1'b1;
        s33 = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        ss  = longint'($signed(a)) + longint'($signed(bb)) + longint'(cin);
        r = s33[31:0];
        c = s33[32];
        v = (ss >= lim) || (ss < -lim);
        upd_res = (op != CMP); upd_nz = 1'b1;
      end
`ifdef MINI_ALU_MUL_EN
      MULS: begin
        ss = longint'($signed(a)) * longint'($signed(b));
        r = ss[31:0];
        upd_res = 1'b1; upd_nz = 1'b1;
      end
`endif
      LSRS, LSLS, ASR, ROR: begin
        r = a;
        for (int i = 0; i < sh; i++) begin
          case (op)
            LSRS:    r = {1'b0, r[31:1]};
            LSLS:    r = {r[30:0], 1'b0};
            ASR:     r = {r[31], r[31:1]};
            default: r = {r[0], r[31:1]};
          endcase
        end
        if (sh != 0) begin
          if (op == LSLS)     c = a[32 - sh];
          else if (op == ROR) c = r[31];
          else                c = a[sh - 1];
        end
        upd_res = 1'b1; upd_nz = 1'b1;
      end
      UXTB: begin r = {24'd0, a[7:0]};          upd_res = 1'b1; end
      UXTH: begin r = {16'd0, a[15:0]};         upd_res = 1'b1; end
      SXTB: begin r = {{24{a[7]}}, a[7:0]};     upd_res = 1'b1; end
      SXTH: begin r = {{16{a[15]}}, a[15:0]};   upd_res = 1'b1; end
      NOP: ;
      default: begin r = '0; upd_res = 1'b1; end
    endcase
    n = upd_nz ? r[31] : m_fl[0];
    z = upd_nz ? (r == 32'd0) : m_fl[1];
    if (upd_res) m_res = r;
    m_fl = {v, c, z, n};
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  fm;
    logic [31:0] mr;
    logic [4:0]  op;
    logic [31:0] ra, rb;
    logic        rr, rv;

`ifdef MINI_ALU_MUL_EN
    fm = 4'b1001; mr = 32'hFFFF_FFEB;
`else
    fm = 4'b1000; mr = 32'h0000_0000;
`endif
    // flags column is {V, C, Z, N}
    add_vec(ADDS, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 4'b0110);
    add_vec(ADCS, 32'h0,         32'h0,         32'h0000_0001, 4'b0000);
    add_vec(ADDS, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001);
    add_vec(SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0001);
    add_vec(CMP,  32'd5,         32'd5,         32'hFFFF_FFFE, 4'b0110);
    add_vec(ANDS, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b0010);
    add_vec(SBCS, 32'd10,        32'd3,         32'h0000_0006, 4'b0100);
    add_vec(EORS, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'b0001);
    add_vec(ASR,  32'h8000_0010, 32'd4,         32'hF800_0001, 4'b0001);
    add_vec(LSRS, 32'h0000_0003, 32'd1,         32'h0000_0001, 4'b0100);
    add_vec(LSLS, 32'h8000_0001, 32'd1,         32'h0000_0002, 4'b0100);
    add_vec(ROR,  32'h0000_0001, 32'd1,         32'h8000_0000, 4'b0101);
    add_vec(LSRS, 32'h0,         32'h0,         32'h0000_0000, 4'b0110);
    add_vec(ADDS, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001);
    add_vec(LSLS, 32'h1,         32'h20,        32'h0000_0001, 4'b1000);
    add_vec(SXTB, 32'h0000_0080, 32'h0,         32'hFFFF_FF80, 4'b1000);
    add_vec(UXTH, 32'hABCD_1234, 32'h0,         32'h0000_1234, 4'b1000);
    add_vec(UXTB, 32'hABCD_12F4, 32'h0,         32'h0000_00F4, 4'b1000);
    add_vec(SXTH, 32'h0000_8001, 32'h0,         32'hFFFF_8001, 4'b1000);
    add_vec(MULS, 32'hFFFF_FFFD, 32'd7,         mr,            fm);
    add_vec(5'd25, 32'd5,        32'd5,         32'h0000_0000, fm);
    add_vec(NOP,  32'd1,         32'd2,         32'h0000_0000, fm);
    add_vec(ORRS, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b1000);
    add_vec(MVNS, 32'h0,         32'h0,         32'hFFFF_FFFF, 4'b1001);
    add_vec(SBCS, 32'h8000_0000, 32'h1,         32'h7FFF_FFFE, 4'b1100);
    add_vec(ADCS, 32'd1,         32'd1,         32'h0000_0003, 4'b0000);
    add_vec(ASR,  32'hC000_0000, 32'd31,        32'hFFFF_FFFF, 4'b0101);
    add_vec(LSLS, 32'h0000_0003, 32'd31,        32'h8000_0000, 4'b0101);
    add_vec(LSRS, 32'hC000_0000, 32'd31,        32'h0000_0001, 4'b0100);

    rst = 1'b1; in_valid = 1'b1; instruction = ADDS; num1 = 32'd5; num2 = 32'd7;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset%0d result", i), result, 32'h0);
      chk($sformatf("reset%0d flags", i), {28'd0, flags}, 32'h0);
      chk($sformatf("reset%0d out_valid", i), {31'd0, out_valid}, 32'h0);
    end
    drive(1'b0, 1'b1, ADDS, 32'd5, 32'd7);
    chk("first_add result", result, 32'd12);
    chk("first_add flags", {28'd0, flags}, 32'h0);
    chk("first_add out_valid", {31'd0, out_valid}, 32'h1);

    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d op%0d result", i, vecs[i].op), result, vecs[i].er);
      chk($sformatf("vec%0d op%0d flags", i, vecs[i].op), {28'd0, flags}, {28'd0, vecs[i].ef});
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'h1);
    end

    // Idle cycles: no pulse, state held despite busy operand inputs.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, ADDS, $urandom, $urandom);
      chk($sformatf("idle%0d out_valid", i), {31'd0, out_valid}, 32'h0);
      chk($sformatf("idle%0d result", i), result, 32'h0000_0001);
      chk($sformatf("idle%0d flags", i), {28'd0, flags}, 32'h4);
    end

    drive(1'b1, 1'b1, ADDS, 32'd1, 32'd1);
    chk("midreset result", result, 32'h0);
    chk("midreset flags", {28'd0, flags}, 32'h0);
    chk("midreset out_valid", {31'd0, out_valid}, 32'h0);

    m_res = '0; m_fl = '0; m_ov = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 99) == 0);
      rv = ($urandom_range(0, 9) != 0);
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 18));
      ra = pick32();
      rb = ($urandom_range(0, 1) == 0) ? pick32() : 32'($urandom_range(0, 40));
      if (rr) begin
        m_res = '0; m_fl = '0; m_ov = 1'b0;
      end else begin
        m_ov = rv;
        if (rv) model_step(op, ra, rb);
      end
      drive(rr, rv, op, ra, rb);
      chk($sformatf("rnd%0d op%0d result", i, op), result, m_res);
      chk($sformatf("rnd%0d op%0d flags", i, op), {28'd0, flags}, {28'd0, m_fl});
      chk($sformatf("rnd%0d out_valid", i), {31'd0, out_valid}, {31'd0, m_ov});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mini_alu_core.md
Name: mini_alu_core

Overview:
- Registered 32-bit integer ALU for the MiniMicro datapath.
- Takes a 5-bit opcode and two 32-bit operands and returns a 32-bit result plus the NZCV status flags.
- Sits between the register file read ports and write-back.
- Flags persist across operations so that ADCS and SBCS can chain on the stored carry.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request; the op is captured when high on a rising edge.
- instruction  input  5  opcode (encoding below).
- num1  input  32  operand A; the value being shifted or extended for shift/extend ops.
- num2  input  32  operand B; bits [4:0] are the shift amount for shift/rotate ops.
- out_valid  output  1  high for exactly one cycle when result/flags reflect a captured op.
- result  output  32  registered result.
- flags  output  4  registered status: [0] N, [1] Z, [2] C, [3] V.

Behaviour:
- Reset (rst high at a rising edge): result=0, flags=0, out_valid=0. Reset wins over a simultaneous in_valid.
- Latency: 1 cycle. An op captured at edge k drives result/flags/out_valid after edge k.
- Cycles with in_valid=0: out_valid=0; result and flags hold their values.
- Back-to-back ops are accepted every cycle. An ADCS/SBCS immediately after an add/sub uses the C written by the previous op.
- Opcodes:
  - 0 NOP: result and flags held; out_valid still pulses.
  - 1 ANDS: A&B.
  - 2 ORRS: A|B.
  - 3 MVNS: ~A.
  - 4 EORS: A^B.
  - 5 ADCS: A+B+C.
  - 6 ADDS: A+B.
  - 7 SBCS: A+~B+C.
  - 8 SUB: A+~B+1.
  - 9 MULS: low 32 bits of the signed product A*B.
  - 10 LSRS, 11 LSLS, 12 ASR, 13 ROR: shift/rotate A by B[4:0].
  - 14 UXTB: zero-extend A[7:0].
  - 15 UXTH: zero-extend A[15:0].
  - 16 SXTB: sign-extend A[7:0].
  - 17 SXTH: sign-extend A[15:0].
  - 18 CMP: A-B with result held.
  - 19-31: undefined; result=0, flags held.
- Flag rules (N = result[31], Z = (result==0) unless noted):
  - Logic ops 1-4: update N and Z; C=0; V held.
  - Add/sub ops 5-8: update N and Z. C = carry-out of bit 31; for subtraction C=1 means no borrow. V = signed overflow (operand signs equal and result sign differs, with B inverted for subtraction).
  - MULS: update N and Z from the low 32 bits; C and V held.
  - Shifts with B[4:0]=0: result=A; N and Z updated; C held.
  - LSRS/ASR C: last bit shifted out, A[sh-1].
  - LSLS C: A[32-sh].
  - ROR C: result[31].
  - Shifts never change V.
  - ASR fills with A[31].
  - Extends (14-17): no flag change.
  - CMP: N, Z, C, V exactly as SUB; result register unchanged.

Optional Feature:
- Macro: MINI_ALU_MUL_EN.
- Defined: opcode 9 computes MULS as above; any multiplier architecture (e.g. Booth) is allowed as long as latency stays at 1 cycle.
- Undefined: no multiplier is synthesized; opcode 9 behaves as an undefined opcode (result=0, flags held).

Test Plan:
- Reset behaviour: assert rst for 2 cycles with in_valid=1, ADDS 5+7 -> result=0, flags=0, out_valid=0. Then release rst and issue ADDS 5+7 -> next cycle result=12, flags=0000, out_valid=1.
- Add carry chain: ADDS 0xFFFFFFFF+0x00000001 -> result=0, Z=1, C=1, V=0. Follow with ADCS 0+0 -> result=1, C=0. ADDS 0x7FFFFFFF+1 -> result=0x80000000, N=1, V=1.
- Subtract and compare: SUB 3-5 -> result=0xFFFFFFFE, N=1, C=0. CMP 5,5 -> Z=1, C=1, result still 0xFFFFFFFE. SBCS 10-3 with C=0 -> result=6.
- Logic ops: ANDS 0xF0F0F0F0 & 0x0F0F0F0F -> result=0, Z=1, C=0. EORS 0xFFFF0000^0x0000FFFF -> result=0xFFFFFFFF, N=1.
- Shifts: ASR 0x80000010 by 4 -> result=0xF8000001, N=1, C=0. LSRS 0x00000003 by 1 -> result=1, C=1. LSLS 0x80000001 by 1 -> result=2, C=1. ROR 0x00000001 by 1 -> result=0x80000000, C=1. Any shift by 0 -> C unchanged.
- Extends and multiply: SXTB 0x00000080 -> result=0xFFFFFF80, flags unchanged. UXTH 0xABCD1234 -> result=0x00001234. With MINI_ALU_MUL_EN: MULS (-3)*7 -> result=0xFFFFFFEB, N=1. Without it: MULS -> result=0, flags held. Opcode 25 -> result=0.
